// File: rtl/ex_stage_md_if.sv
// ex_stage_md_if: bundles the EX-stage pipeline signals.
//   master: drives forwarding sources, ID/EX operands and control, Flush;
//           observes the EX/MEM register outputs and Stall.
//   slave : the EX stage itself (ex_stage_md).
// Parameters: WIDTH = datapath width, RADDR = register-address width.
interface ex_stage_md_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RADDR = 5
);
    // Forwarding sources
    logic             MEMRegWrite;
    logic [WIDTH-1:0] MEMData;
    logic [RADDR-1:0] MEMRd;
    logic             WBRegWrite;
    logic [WIDTH-1:0] WBData;
    logic [RADDR-1:0] WBRd;
    // ID/EX inputs
    logic             ALUSrc;
    logic [2:0]       ALUControl;
    logic             MemRead;
    logic             MemWrite;
    logic             RegWrite;
    logic [WIDTH-1:0] DataA;
    logic [WIDTH-1:0] DataB;
    logic [WIDTH-1:0] SignExtend;
    logic [RADDR-1:0] Rs;
    logic [RADDR-1:0] Rt;
    logic [RADDR-1:0] Rd;
    logic             Flush;
    // EX/MEM outputs
    logic             EXRegWrite;
    logic             EXMemRead;
    logic             EXMemWrite;
    logic [RADDR-1:0] EXRd;
    logic [WIDTH-1:0] EXData;
    logic [WIDTH-1:0] EXALUData;
    logic             Stall;

    modport master (
        output MEMRegWrite, MEMData, MEMRd, WBRegWrite, WBData, WBRd,
        output ALUSrc, ALUControl, MemRead, MemWrite, RegWrite,
        output DataA, DataB, SignExtend, Rs, Rt, Rd, Flush,
        input  EXRegWrite, EXMemRead, EXMemWrite, EXRd, EXData, EXALUData, Stall
    );

    modport slave (
        input  MEMRegWrite, MEMData, MEMRd, WBRegWrite, WBData, WBRd,
        input  ALUSrc, ALUControl, MemRead, MemWrite, RegWrite,
        input  DataA, DataB, SignExtend, Rs, Rt, Rd, Flush,
        output EXRegWrite, EXMemRead, EXMemWrite, EXRd, EXData, EXALUData, Stall
    );
endinterface

// File: rtl/ex_stage_md.sv
// ex_stage_md: pipeline execute stage with MEM/WB operand forwarding, a
// single-cycle ALU and a multi-cycle shift-add multiplier, feeding the
// EX/MEM pipeline register.
// Ports:
//   Clk - clock, rising edge
//   Rst - asynchronous active-high reset
//   bus - ex_stage_md_if.slave: forwarding sources, operands, control,
//         Flush in; EX/MEM register and combinational Stall out.
module ex_stage_md #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RADDR = 5
) (
    input logic          Clk,
    input logic          Rst,
    ex_stage_md_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mulState_e;

    mulState_e        state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] mulCand;
    logic [WIDTH-1:0] mulPlier;
    logic [WIDTH-1:0] mulAcc;

    logic [WIDTH-1:0] fwdA;
    logic [WIDTH-1:0] fwdB;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] aluResult;
    logic             isMul;
    logic             stall;

    // MEM beats WB; register 0 is never forwarded.
    always_comb begin
        fwdA = bus.DataA;
        if (bus.MEMRegWrite && (bus.MEMRd != '0) && (bus.MEMRd == bus.Rs)) begin
            fwdA = bus.MEMData;
        end else if (bus.WBRegWrite && (bus.WBRd != '0) && (bus.WBRd == bus.Rs)) begin
            fwdA = bus.WBData;
        end
    end

    always_comb begin
        fwdB = bus.DataB;
        if (bus.MEMRegWrite && (bus.MEMRd != '0) && (bus.MEMRd == bus.Rt)) begin
            fwdB = bus.MEMData;
        end else if (bus.WBRegWrite && (bus.WBRd != '0) && (bus.WBRd == bus.Rt)) begin
            fwdB = bus.WBData;
        end
    end

    assign opB = bus.ALUSrc ? bus.SignExtend : fwdB;

    // 011 (MUL) goes through the sequential multiplier; 100/101 give zero.
    always_comb begin
        aluResult = '0;
        case (bus.ALUControl)
            3'b000:  aluResult = fwdA & opB;
            3'b001:  aluResult = fwdA | opB;
            3'b010:  aluResult = fwdA + opB;
            3'b110:  aluResult = fwdA - opB;
            3'b111:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(fwdA) < $signed(opB))};
            default: aluResult = '0;
        endcase
    end

    assign isMul   = (bus.ALUControl == 3'b011);
    assign stall   = isMul && (state != StDone);
    assign bus.Stall = stall;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bus.EXRegWrite <= 1'b0;
            bus.EXMemRead  <= 1'b0;
            bus.EXMemWrite <= 1'b0;
            bus.EXRd       <= '0;
            bus.EXData     <= '0;
            bus.EXALUData  <= '0;
            state          <= StIdle;
            counter        <= '0;
            mulCand        <= '0;
            mulPlier       <= '0;
            mulAcc         <= '0;
        end else begin
            // EX/MEM register: bubble on flush or stall, data fields hold.
            if (bus.Flush || stall) begin
                bus.EXRegWrite <= 1'b0;
                bus.EXMemRead  <= 1'b0;
                bus.EXMemWrite <= 1'b0;
                bus.EXRd       <= '0;
            end else begin
                bus.EXRegWrite <= bus.RegWrite;
                bus.EXMemRead  <= bus.MemRead;
                bus.EXMemWrite <= bus.MemWrite;
                bus.EXRd       <= bus.Rd;
                bus.EXData     <= fwdB;
                bus.EXALUData  <= (state == StDone) ? mulAcc : aluResult;
            end

            // Multiplier sequencer
            if (bus.Flush) begin
                state   <= StIdle;
                counter <= '0;
            end else begin
                case (state)
                    StIdle: begin
                        if (isMul) begin
                            // Operands latched here so later forwarding changes are ignored.
                            mulCand  <= fwdA;
                            mulPlier <= opB;
                            mulAcc   <= '0;
                            counter  <= CW'(WIDTH);
                            state    <= StBusy;
                        end
                    end
                    StBusy: begin
                        if (mulPlier[0]) begin
                            mulAcc <= mulAcc + mulCand;
                        end
                        mulCand  <= mulCand << 1;
                        mulPlier <= mulPlier >> 1;
                        counter  <= counter - CW'(1);
                        if (counter == CW'(1)) begin
                            state <= StDone;
                        end
                    end
                    StDone: begin
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_md.sv
module tb_ex_stage_md;
    logic Clk;
    logic Rst;
    int   total;
    int   bad;
    int   cnt;

    ex_stage_md_if #(.WIDTH(32), .RADDR(5)) bus ();

    ex_stage_md #(.WIDTH(32), .RADDR(5)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clearIn();
        bus.MEMRegWrite = 1'b0; bus.MEMData = '0; bus.MEMRd = '0;
        bus.WBRegWrite  = 1'b0; bus.WBData  = '0; bus.WBRd  = '0;
        bus.ALUSrc = 1'b0; bus.ALUControl = 3'b000;
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.RegWrite = 1'b0;
        bus.DataA = '0; bus.DataB = '0; bus.SignExtend = '0;
        bus.Rs = '0; bus.Rt = '0; bus.Rd = '0; bus.Flush = 1'b0;
    endtask

    // Counts cycles with Stall high, stepping an edge each; bounded.
    task automatic countStall(output int n);
        n = 0;
        while (bus.Stall === 1'b1 && n < 100) begin
            n++;
            step();
            chk("stall_bubble_rw", {31'b0, bus.EXRegWrite}, 32'd0);
        end
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "_rw"}, {31'b0, bus.EXRegWrite}, 32'd0);
        chk({tag, "_mr"}, {31'b0, bus.EXMemRead}, 32'd0);
        chk({tag, "_mw"}, {31'b0, bus.EXMemWrite}, 32'd0);
        chk({tag, "_rd"}, {27'b0, bus.EXRd}, 32'd0);
        chk({tag, "_data"}, bus.EXData, 32'd0);
        chk({tag, "_alu"}, bus.EXALUData, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Clk   = 1'b0;
        Rst   = 1'b1;
        clearIn();
        bus.ALUControl = 3'b011;
        step();
        chkZero("reset");
        chk("reset_stall_mul", {31'b0, bus.Stall}, 32'd1);
        bus.ALUControl = 3'b000;
        #1;
        chk("reset_stall_and", {31'b0, bus.Stall}, 32'd0);
        Rst = 1'b0;

        // OR, no forwarding
        bus.Rs = 5'd1; bus.Rt = 5'd2;
        bus.DataA = 32'hdead_0000; bus.DataB = 32'h0000_beef;
        bus.ALUControl = 3'b001; bus.RegWrite = 1'b1; bus.Rd = 5'd5;
        step();
        chk("or_alu", bus.EXALUData, 32'hdead_beef);
        chk("or_data", bus.EXData, 32'h0000_beef);
        chk("or_rw", {31'b0, bus.EXRegWrite}, 32'd1);
        chk("or_rd", {27'b0, bus.EXRd}, 32'd5);

        // MEM over WB priority
        bus.MEMRegWrite = 1'b1; bus.MEMRd = 5'd1; bus.MEMData = 32'h1234_0000;
        bus.WBRegWrite  = 1'b1; bus.WBRd  = 5'd1; bus.WBData  = 32'habcd_0000;
        bus.DataA = '0; bus.DataB = '0;
        step();
        chk("fwd_mem_prio", bus.EXALUData, 32'h1234_0000);
        bus.MEMRegWrite = 1'b0;
        step();
        chk("fwd_wb", bus.EXALUData, 32'habcd_0000);

        // Forward on B, store data is forwarded B
        bus.MEMRegWrite = 1'b1; bus.Rs = 5'd4; bus.Rt = 5'd1; bus.DataA = 32'd1;
        bus.ALUControl = 3'b010; bus.MemWrite = 1'b1; bus.RegWrite = 1'b0;
        step();
        chk("fwdb_alu", bus.EXALUData, 32'h1234_0001);
        chk("fwdb_data", bus.EXData, 32'h1234_0000);
        chk("fwdb_mw", {31'b0, bus.EXMemWrite}, 32'd1);
        chk("fwdb_rw", {31'b0, bus.EXRegWrite}, 32'd0);

        // Register 0 never forwarded; immediate operand
        bus.MEMRegWrite = 1'b0; bus.MemWrite = 1'b0; bus.RegWrite = 1'b1;
        bus.WBRegWrite = 1'b1; bus.WBRd = 5'd0; bus.WBData = 32'hffff_ffff;
        bus.Rs = 5'd0; bus.Rt = 5'd0; bus.DataA = 32'd5; bus.DataB = 32'd0;
        bus.ALUSrc = 1'b1; bus.SignExtend = 32'd3;
        step();
        chk("r0_imm_alu", bus.EXALUData, 32'h0000_0008);
        chk("r0_imm_data", bus.EXData, 32'd0);

        // SLT signed both ways, SUB, AND, unused codes
        bus.ALUSrc = 1'b0; bus.WBRegWrite = 1'b0; bus.Rs = 5'd7; bus.Rt = 5'd8;
        bus.DataA = 32'hffff_ffff; bus.DataB = 32'h0000_0001; bus.ALUControl = 3'b111;
        step();
        chk("slt_neg", bus.EXALUData, 32'd1);
        bus.DataA = 32'h0000_0001; bus.DataB = 32'hffff_ffff;
        step();
        chk("slt_pos", bus.EXALUData, 32'd0);
        bus.DataA = 32'd3; bus.DataB = 32'd5; bus.ALUControl = 3'b110;
        step();
        chk("sub_wrap", bus.EXALUData, 32'hffff_fffe);
        bus.DataA = 32'hf0f0_ff00; bus.DataB = 32'h0ff0_0ff0; bus.ALUControl = 3'b000;
        step();
        chk("and", bus.EXALUData, 32'h00f0_0f00);
        bus.DataA = 32'hffff_ffff; bus.DataB = 32'hffff_ffff; bus.ALUControl = 3'b100;
        step();
        chk("op100", bus.EXALUData, 32'd0);
        bus.ALUControl = 3'b010;
        step();
        chk("add_wrap", bus.EXALUData, 32'hffff_fffe);
        bus.ALUControl = 3'b101;
        step();
        chk("op101", bus.EXALUData, 32'd0);

        // MUL 0x1234 * 0x10, forwarding inputs disturbed mid-BUSY
        bus.Rs = 5'd1; bus.Rt = 5'd2;
        bus.DataA = 32'h0000_1234; bus.DataB = 32'h0000_0010;
        bus.ALUControl = 3'b011; bus.RegWrite = 1'b1; bus.Rd = 5'd3;
        #1;
        chk("mul_stall_issue", {31'b0, bus.Stall}, 32'd1);
        cnt = 0;
        while (bus.Stall === 1'b1 && cnt < 100) begin
            cnt++;
            step();
            chk("mul_bubble_rw", {31'b0, bus.EXRegWrite}, 32'd0);
            chk("mul_bubble_rd", {27'b0, bus.EXRd}, 32'd0);
            if (cnt == 5) begin
                bus.MEMRegWrite = 1'b1; bus.MEMRd = 5'd1; bus.MEMData = 32'hffff_ffff;
            end
        end
        chk("mul_stall_cycles", cnt, 32'd33);
        chk("mul_done_stall", {31'b0, bus.Stall}, 32'd0);
        step();
        chk("mul_result", bus.EXALUData, 32'h0001_2340);
        chk("mul_rw", {31'b0, bus.EXRegWrite}, 32'd1);
        chk("mul_rd", {27'b0, bus.EXRd}, 32'd3);

        // Flush on the 10th BUSY cycle
        bus.MEMRegWrite = 1'b0;
        bus.DataA = 32'd7; bus.DataB = 32'd9; bus.Rd = 5'd6;
        step();
        repeat (9) step();
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0; bus.ALUControl = 3'b010;
        chk("flush_rw", {31'b0, bus.EXRegWrite}, 32'd0);
        chk("flush_rd", {27'b0, bus.EXRd}, 32'd0);
        chk("flush_alu_hold", bus.EXALUData, 32'h0001_2340);
        #1;
        chk("flush_stall", {31'b0, bus.Stall}, 32'd0);
        bus.DataA = 32'd2; bus.DataB = 32'd2;
        step();
        chk("post_flush_add", bus.EXALUData, 32'd4);
        chk("post_flush_rd", {27'b0, bus.EXRd}, 32'd6);

        // A fresh MUL after the flush must take the full latency
        bus.DataA = 32'd2; bus.DataB = 32'd3; bus.ALUControl = 3'b011; bus.Rd = 5'd3;
        #1;
        countStall(cnt);
        chk("post_flush_mul_cycles", cnt, 32'd33);
        step();
        chk("post_flush_mul", bus.EXALUData, 32'd6);

        // Async reset mid-multiply while Clk is low
        bus.DataA = 32'd5; bus.DataB = 32'd6; bus.Rd = 5'd7;
        step();
        repeat (3) step();
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chkZero("async_rst");
        chk("async_rst_stall", {31'b0, bus.Stall}, 32'd1);
        Rst = 1'b0;
        #1;
        countStall(cnt);
        chk("post_rst_mul_cycles", cnt, 32'd33);
        step();
        chk("post_rst_mul", bus.EXALUData, 32'd30);
        chk("post_rst_rd", {27'b0, bus.EXRd}, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_stage_md.md
EX_STAGE_MD -- requirements
Module: ex_stage_md

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; legal values 8 or more.
REQ-002 Parameter RADDR, default 5: register-address width in bits.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Rst  input  1  reset; asynchronous, active-high.
REQ-005 MEMRegWrite / MEMData / MEMRd  input  1 / WIDTH / RADDR  forwarding source, one instruction ahead.
REQ-006 WBRegWrite / WBData / WBRd  input  1 / WIDTH / RADDR  forwarding source, two instructions ahead.
REQ-007 ALUSrc  input  1  1 = ALU operand B is SignExtend; ALUControl  input  3  operation select.
REQ-008 MemRead / MemWrite / RegWrite  input  1 each  control bits passed to the EX/MEM register.
REQ-009 DataA / DataB / SignExtend  input  WIDTH  register-file read values and immediate.
REQ-010 Rs / Rt / Rd  input  RADDR  source and destination register numbers.
REQ-011 Flush  input  1  synchronous kill of the current EX instruction.
REQ-012 EXRegWrite / EXMemRead / EXMemWrite  output  1 each  registered control bits.
REQ-013 EXRd  output  RADDR  registered destination register.
REQ-014 EXData  output  WIDTH  registered store data, which is the forwarded Rt value.
REQ-015 EXALUData  output  WIDTH  registered ALU or multiply result.
REQ-016 Stall  output  1  combinational; high means upstream must hold all inputs stable.

Function
REQ-017 Forwarded A SHALL be:
  - MEMData if MEMRegWrite=1, MEMRd!=0 and MEMRd==Rs;
  - else WBData if WBRegWrite=1, WBRd!=0 and WBRd==Rs;
  - else DataA.
  Forwarded B SHALL use the same rule with Rt and DataB.
REQ-018 MEM-stage forwarding SHALL take priority over WB-stage forwarding; register 0 SHALL never be forwarded.
REQ-019 ALU operand B SHALL be SignExtend when ALUSrc=1, else forwarded B; EXData SHALL always capture forwarded B.
REQ-020 ALUControl encodings:
  - 000 AND; 001 OR; 010 ADD; 110 SUB, both modulo 2^WIDTH;
  - 111 SLT: result 1 if A<B as signed values, else 0;
  - 011 MUL: unsigned, low WIDTH bits of the product;
  - 100 and 101: result 0.
REQ-021 Non-MUL operations SHALL have latency 1: inputs present before a rising edge appear on the EX outputs after that edge.
REQ-022 MUL issue: when idle, ALUControl=011 and Flush=0, the block latches forwarded A and ALU operand B, loads counter=WIDTH, and enters BUSY.
REQ-023 BUSY: one shift-add iteration per edge, counter decrements; on the edge where the counter reaches 0 the block enters DONE.
REQ-024 DONE: on the next edge the EX/MEM register captures the product together with that instruction's control bits and Rd, and the block returns to IDLE.
REQ-025 Stall SHALL equal (ALUControl==011 and state!=DONE); it is high for WIDTH+1 cycles per MUL and low during the DONE cycle.
REQ-026 While Stall=1, each edge SHALL load a bubble into EX/MEM: EXRegWrite, EXMemRead and EXMemWrite = 0, EXRd = 0; EXData and EXALUData hold their values.
REQ-027 Multiply operands are latched at issue, so changes on the forwarding inputs during BUSY SHALL NOT affect the product.
REQ-028 Flush=1 at an edge SHALL:
  - load a bubble into EX/MEM;
  - abort any BUSY or DONE multiply and return to IDLE with counter 0;
  - take priority over issue and capture.
  After a flush, Stall follows REQ-025 with state IDLE.

Reset
REQ-029 While Rst=1, all outputs SHALL be 0 immediately, independent of Clk: EXRegWrite, EXMemRead, EXMemWrite, EXRd, EXData, EXALUData; state=IDLE, counter=0; Stall then depends only on ALUControl.
REQ-030 Rst asserted mid-multiply SHALL discard the operation; the first edge after deassertion behaves as an IDLE cycle.

Verification
REQ-031 OR: DataA=dead_0000, DataB=0000_beef, ALUSrc=0, no forwarding, one edge -> EXALUData=dead_beef, EXData=0000_beef.
REQ-032 Forward priority: Rs=1, MEMRd=WBRd=1, both RegWrite=1, MEMData=1234_0000, WBData=abcd_0000, DataB=0, OR -> EXALUData=1234_0000.
REQ-033 Register 0 and immediate: Rs=0, WBRd=0, WBRegWrite=1, WBData=ffff_ffff, DataA=5, ALUSrc=1, SignExtend=3, ADD -> EXALUData=0000_0008.
REQ-034 SLT: DataA=ffff_ffff, DataB=0000_0001, code 111 -> EXALUData=0000_0001.
REQ-035 MUL, WIDTH=32: A=0000_1234, B=0000_0010, RegWrite=1, Rd=3 ->
  - Stall high 33 cycles, EXRegWrite=0 throughout;
  - then EXALUData=0001_2340, EXRegWrite=1, EXRd=3.
REQ-036 Flush on the 10th BUSY cycle -> next edge gives a bubble and Stall=0 with ALUControl changed to ADD; a following ADD 2+2 -> EXALUData=4. Separately, Rst pulsed while Clk=0 -> all outputs 0 immediately.
